// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock ratio meter and related measurement blocks.
package clk_meas_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // All-ones value of a counter of width w; counters stop here instead of wrapping.
  function automatic longint unsigned sat_of(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  localparam longint unsigned CNT_SAT_DEF = sat_of(CNT_W_DEF);

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Measured signal and measurement results of the clock ratio meter.
interface clk_ratio_meter_if
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, valid, locked, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, valid, locked, timeout
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with rising-edge detection; level and rise are
// registered and mutually aligned.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sync_r;

  // Synchronizer chain, delay flop and registered edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      level  <= sync_r[STAGES-1];
      rise   <= sync_r[STAGES-1] & ~level;
    end
  end
endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles
// and reports lock once consecutive periods agree.
module clk_ratio_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  clk_ratio_meter_if.slave bus
);
  localparam int                 MATCH_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(sat_of(CNT_W));
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);

  logic               level_s;
  logic               rise_s;
  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   hcnt_r;
  logic [MATCH_W-1:0] match_r;
  logic [MATCH_W-1:0] match_nx_s;
  logic               meas_s;
  logic               tmo_s;
  logic [CNT_W-1:0]   period_r;
  logic [CNT_W-1:0]   high_r;
  logic               valid_r;
  logic               locked_r;
  logic               timeout_r;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.sig_in),
    .level    (level_s),
    .rise     (rise_s)
  );

  // Period and high-time counters, restarted by every rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= CNT_W'(0);
      hcnt_r <= CNT_W'(0);
    end else if (rise_s) begin
      cnt_r  <= CNT_W'(1);
      hcnt_r <= CNT_W'(1);
    end else begin
      if (cnt_r != CNT_SAT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (level_s && (hcnt_r != CNT_SAT)) begin
        hcnt_r <= hcnt_r + CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, measurement/timeout events and match tracking.
  always_comb begin
    state_nx_s = state_r;
    meas_s     = 1'b0;
    tmo_s      = 1'b0;
    match_nx_s = match_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nx_s = MEASURE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          meas_s = 1'b1;
          // match_r == 0 marks the first measurement since IDLE: nothing to compare.
          if (match_r == MATCH_W'(0)) begin
            match_nx_s = MATCH_W'(1);
          end else if (cnt_r == period_r) begin
            if (match_r == MATCH_LOCK) begin
              match_nx_s = match_r;
            end else begin
              match_nx_s = match_r + MATCH_W'(1);
            end
          end else begin
            match_nx_s = MATCH_W'(1);
          end
        end else if (cnt_r == CNT_SAT) begin
          tmo_s      = 1'b1;
          match_nx_s = MATCH_W'(0);
          state_nx_s = IDLE;
        end else begin
          state_nx_s = MEASURE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        match_nx_s = MATCH_W'(0);
      end
    endcase
  end

  // Registered results, lock and timeout status.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_r  <= CNT_W'(0);
      high_r    <= CNT_W'(0);
      valid_r   <= 1'b0;
      locked_r  <= 1'b0;
      timeout_r <= 1'b0;
      match_r   <= MATCH_W'(0);
    end else begin
      valid_r <= meas_s;
      match_r <= match_nx_s;
      if (meas_s) begin
        period_r <= cnt_r;
        high_r   <= hcnt_r;
        locked_r <= (match_nx_s == MATCH_LOCK);
      end else if (tmo_s) begin
        locked_r <= 1'b0;
      end
      if (rise_s) begin
        timeout_r <= 1'b0;
      end else if (tmo_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign bus.period    = period_r;
  assign bus.high_time = high_r;
  assign bus.valid     = valid_r;
  assign bus.locked    = locked_r;
  assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter: a rise-time based reference model
// checks every cycle, plus directed checks at the scenario boundaries.
module tb_clk_ratio_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W = CNT_W_DEF;
  localparam int LOCK  = 4;
  localparam int SAT   = int'(sat_of(CNT_W));

  logic clk   = 1'b0;
  logic reset = 1'b1;

  clk_ratio_meter_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_meter #(
    .CNT_W       (CNT_W),
    .LOCK_COUNT  (LOCK),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_valid = 0;
  logic hist     [0:65535];
  logic rst_hist [0:65535];

  // What the DUT samples on each clock edge, indexed by edge number.
  always @(posedge clk) begin
    hist[cyc]     <= bus.sig_in;
    rst_hist[cyc] <= reset;
    cyc           <= cyc + 1;
  end

  // Reference model state, expressed in terms of sampled rise times.
  bit measuring = 1'b0;
  int prev_rise = 0;
  int base      = 0;
  int match     = 0;
  int m_per     = 0;
  int m_high    = 0;
  bit m_valid   = 1'b0;
  bit m_locked  = 1'b0;
  bit m_tmo     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Outputs after edge p reflect the sample taken three edges earlier.
  task automatic model_step(input int p);
    int m;
    int g;
    int hi;
    bit r;
    if (rst_hist[p] === 1'b1) begin
      measuring = 1'b0;
      match     = 0;
      m_per     = 0;
      m_high    = 0;
      m_valid   = 1'b0;
      m_locked  = 1'b0;
      m_tmo     = 1'b0;
      base      = p + 1;
    end else begin
      m_valid = 1'b0;
      m       = p - 3;
      if (m >= base) begin
        r = (hist[m] === 1'b1) && !((m - 1 >= base) && (hist[m-1] === 1'b1));
        if (r) begin
          if (measuring) begin
            g  = m - prev_rise;
            hi = 0;
            for (int k = prev_rise; k < m; k++) if (hist[k] === 1'b1) hi++;
            if (hi > SAT) hi = SAT;
            if (match == 0) match = 1;
            else if (g == m_per) match = (match < LOCK) ? match + 1 : LOCK;
            else match = 1;
            m_valid  = 1'b1;
            m_per    = g;
            m_high   = hi;
            m_locked = (match == LOCK);
          end else begin
            measuring = 1'b1;
          end
          m_tmo     = 1'b0;
          prev_rise = m;
        end else if (measuring && (m - prev_rise == SAT)) begin
          m_tmo     = 1'b1;
          m_locked  = 1'b0;
          match     = 0;
          measuring = 1'b0;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      model_step(cyc - 1);
      check("valid",     bus.valid,     m_valid);
      check("locked",    bus.locked,    m_locked);
      check("timeout",   bus.timeout,   m_tmo);
      check("period",    bus.period,    m_per);
      check("high_time", bus.high_time, m_high);
      if (bus.valid === 1'b1) n_valid++;
    end
  endtask

  task automatic drive_div(input int div, input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        bus.sig_in = (c < div / 2);
      end
    end
  endtask

  task automatic drive_pulse(input int gap);
    @(negedge clk);
    bus.sig_in = 1'b1;
    repeat (gap - 1) begin
      @(negedge clk);
      bus.sig_in = 1'b0;
    end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.sig_in = 1'b0;
    end
  endtask

  int nv0;
  int off;
  int div;

  initial begin
    bus.sig_in = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    fork
      monitor_loop();
    join_none
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_period",  bus.period,    0);
    check("rst_high",    bus.high_time, 0);
    check("rst_valid",   bus.valid,     0);
    check("rst_locked",  bus.locked,    0);
    check("rst_timeout", bus.timeout,   0);

    // Divider 16, synchronous.
    drive_div(16, 8);
    check("d16_locked", bus.locked,    1);
    check("d16_period", bus.period,    16);
    check("d16_high",   bus.high_time, 8);

    // Divider 10, then 12.
    drive_div(10, 8);
    check("d10_locked", bus.locked, 1);
    check("d10_period", bus.period, 10);
    drive_div(12, 2);
    check("sw_unlocked", bus.locked, 0);
    check("sw_period",   bus.period, 12);
    drive_div(12, 4);
    check("d12_locked", bus.locked,    1);
    check("d12_period", bus.period,    12);
    check("d12_high",   bus.high_time, 6);

    // Timeout after lock at 16.
    drive_div(16, 8);
    check("pre_tmo_locked", bus.locked, 1);
    hold_low(300);
    check("tmo_set",    bus.timeout,   1);
    check("tmo_locked", bus.locked,    0);
    check("tmo_period", bus.period,    16);
    check("tmo_high",   bus.high_time, 8);
    nv0 = n_valid;
    drive_div(16, 1);
    check("tmo_clear",     bus.timeout, 0);
    check("tmo_no_valid",  n_valid,     nv0);
    drive_div(16, 1);
    check("tmo_next_valid", n_valid, nv0 + 1);

    // Reset while locked.
    drive_div(16, 8);
    check("prerst_locked", bus.locked, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_period",  bus.period,    0);
    check("mid_rst_high",    bus.high_time, 0);
    check("mid_rst_valid",   bus.valid,     0);
    check("mid_rst_locked",  bus.locked,    0);
    check("mid_rst_timeout", bus.timeout,   0);
    nv0 = n_valid;
    drive_div(16, 1);
    check("rst_first_rise", n_valid, nv0);
    drive_div(16, 1);
    check("rst_second_rise", n_valid, nv0 + 1);

    // Asynchronous signal, period 16.5 clk cycles.
    @(negedge clk);
    off = int'($urandom_range(4, 1));
    #(off);
    repeat (20) begin
      bus.sig_in = 1'b1;
      #80;
      bus.sig_in = 1'b0;
      #85;
    end
    @(negedge clk);
    check("async_locked", bus.locked, 0);
    check("async_period", (bus.period == 8'd16) || (bus.period == 8'd17), 1);
    check("async_high",   (bus.high_time >= 8'd7) && (bus.high_time <= 8'd9), 1);

    // Rise coinciding with counter saturation.
    drive_pulse(SAT);
    drive_pulse(SAT);
    drive_pulse(SAT);
    check("sat_period",  bus.period,    SAT);
    check("sat_high",    bus.high_time, 1);
    check("sat_timeout", bus.timeout,   0);

    // Toggle every cycle.
    drive_div(2, 12);
    check("tgl_locked", bus.locked,    1);
    check("tgl_period", bus.period,    2);
    check("tgl_high",   bus.high_time, 1);

    // Random dividers.
    for (int i = 0; i < 3; i++) begin
      div = int'($urandom_range(40, 4));
      drive_div(div, 8);
      check("rnd_locked", bus.locked,    1);
      check("rnd_period", bus.period,    div);
      check("rnd_high",   bus.high_time, div / 2);
    end

    hold_low(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
